weight_bram_sequencer: RTL

Controller for one 28-entry, 16-bit weight BRAM in the ANN datapath. It arbitrates between two requesters, a host loader that rewrites the whole weight vector and the neuron MAC that streams the weights out in address order. It drives the BRAM's ADDR/DI/EN/WE pins and presents read data to the MAC as a valid/ready stream. It sits between the weight-load bus, the MAC and the BRAM.

---
 rtl/weight_bram_sequencer_pkg.sv | 24 ++
 rtl/weight_bram_sequencer_rr_arb2.sv | 29 ++
 rtl/weight_bram_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/weight_bram_sequencer_pkg.sv
// Shared constants and encodings for the ANN weight sequencers.
// Other weight sequencers import this package as well.
package weight_bram_sequencer_pkg;

   localparam int DEPTH = 28;
   localparam int AW    = 5;
   localparam int DW    = 16;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] END_ADDR  = AW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   typedef enum logic {
      SRV_LOADER = 1'b0,
      SRV_MAC    = 1'b1
   } served_t;

endpackage

// File: rtl/weight_bram_sequencer_rr_arb2.sv
// Two-requester round-robin arbiter: a tie goes to the side that was not served last.
module rr_arb2
   import weight_bram_sequencer_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_req_ld,
   input  logic i_req_rd,
   output logic o_gnt_ld,
   output logic o_gnt_rd
);

   served_t r_last_served;

   assign o_gnt_ld = i_en & i_req_ld & (~i_req_rd | (r_last_served == SRV_MAC));
   assign o_gnt_rd = i_en & i_req_rd & (~i_req_ld | (r_last_served == SRV_LOADER));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_served <= SRV_LOADER;
      end else if (o_gnt_ld) begin
         r_last_served <= SRV_LOADER;
      end else if (o_gnt_rd) begin
         r_last_served <= SRV_MAC;
      end
   end

endmodule

// File: rtl/weight_bram_sequencer.sv
// Arbitrates the weight loader and the MAC for one weight BRAM; writes full vectors
// and streams them back in address order over a valid/ready interface.
module weight_bram_sequencer
   import weight_bram_sequencer_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_ld_req,
   output logic          o_ld_gnt,
   input  logic          i_wr_valid,
   input  logic [DW-1:0] i_wr_data,
   output logic          o_wr_ready,
   output logic          o_ld_done,
   input  logic          i_rd_req,
   output logic          o_rd_gnt,
   output logic          o_out_valid,
   output logic [DW-1:0] o_out_data,
   output logic          o_out_last,
   input  logic          i_out_ready,
   output logic          o_busy,
   output logic [AW-1:0] o_bram_addr,
   output logic [DW-1:0] o_bram_di,
   output logic          o_bram_en,
   output logic          o_bram_we,
   input  logic [DW-1:0] i_bram_do
);

   state_t        r_state;
   logic [AW-1:0] r_wcnt;
   logic [AW-1:0] r_rcnt;
   logic          r_ld_gnt;
   logic          r_rd_gnt;
   logic          r_ld_done;
   logic          r_out_valid;
   logic          r_out_last;

   logic          w_arb_en;
   logic          w_gnt_ld;
   logic          w_gnt_rd;
   logic          w_wr_fire;
   logic          w_issue;

   assign w_arb_en  = (r_state == ST_IDLE);
   assign w_wr_fire = (r_state == ST_LOAD) & i_wr_valid;
   // Issue only when the output slot is empty or being emptied this cycle, so BRAM DO holds while stalled.
   assign w_issue   = (r_state == ST_STREAM) & (r_rcnt < END_ADDR) & (~r_out_valid | i_out_ready);

   rr_arb2 u_arb (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_arb_en),
      .i_req_ld (i_ld_req),
      .i_req_rd (i_rd_req),
      .o_gnt_ld (w_gnt_ld),
      .o_gnt_rd (w_gnt_rd)
   );

   assign o_bram_en   = w_wr_fire | w_issue;
   assign o_bram_we   = w_wr_fire;
   assign o_bram_addr = w_wr_fire ? r_wcnt : (w_issue ? r_rcnt : '0);
   assign o_bram_di   = w_wr_fire ? i_wr_data : '0;

   assign o_wr_ready  = (r_state == ST_LOAD);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_ld_gnt    = r_ld_gnt;
   assign o_rd_gnt    = r_rd_gnt;
   assign o_ld_done   = r_ld_done;
   assign o_out_valid = r_out_valid;
   assign o_out_last  = r_out_last;
   assign o_out_data  = i_bram_do;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_wcnt      <= '0;
         r_rcnt      <= '0;
         r_ld_gnt    <= 1'b0;
         r_rd_gnt    <= 1'b0;
         r_ld_done   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_ld_gnt    <= 1'b0;
         r_rd_gnt    <= 1'b0;
         r_ld_done   <= 1'b0;
         r_out_valid <= w_issue | (r_out_valid & ~i_out_ready);
         if (w_issue) begin
            r_out_last <= (r_rcnt == LAST_ADDR);
         end else if (i_out_ready) begin
            r_out_last <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_gnt_ld) begin
                  r_ld_gnt <= 1'b1;
                  r_state  <= ST_LOAD;
               end else if (w_gnt_rd) begin
                  r_rd_gnt <= 1'b1;
                  r_state  <= ST_STREAM;
               end
            end
            ST_LOAD: begin
               if (w_wr_fire) begin
                  if (r_wcnt == LAST_ADDR) begin
                     r_wcnt    <= '0;
                     r_ld_done <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            ST_STREAM: begin
               if (w_issue) begin
                  r_rcnt <= r_rcnt + 1'b1;
                  if (r_rcnt == LAST_ADDR) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_out_valid & i_out_ready) begin
                  r_rcnt  <= '0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
